// File: rtl/lcd_fifo_rd_ctl.sv
// lcd_fifo_rd_ctl: panel timing generator that drains the pixel FIFO onto the LCD pins.
module lcd_fifo_rd_ctl #(
    parameter int DATA_W = 16,
    parameter int CNT_W = 11,
    parameter int START_LEVEL = 512,
    parameter int H_SYNC = 128,
    parameter int H_BP = 88,
    parameter int H_ACTIVE = 800,
    parameter int H_FP = 40,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter bit SYNC_POL = 1'b0,
    parameter logic [DATA_W-1:0] UNDERFLOW_COLOR = 16'hF800
) (
    input  logic              fifo_rd_clk,
    input  logic              rst,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_rd_cnt,
    output logic              lcd_framesync,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic              lcd_de,
    output logic [DATA_W-1:0] lcd_data,
    output logic              underflow
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam logic [HW-1:0] H_S = HW'(H_SYNC);
    localparam logic [HW-1:0] H_A0 = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_A1 = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [HW-1:0] H_L = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_S = VW'(V_SYNC);
    localparam logic [VW-1:0] V_A0 = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_A1 = VW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [VW-1:0] V_L = VW'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] START = CNT_W'(START_LEVEL);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic run, last, hs0, vs0, act0;
    logic hs1, vs1, act1, pop1;
    logic frame_bad, armed, idle_pulse;

    assign run = (state == RUN);
    assign last = (h_cnt == H_L) && (v_cnt == V_L);
    // Stage 0 is gated by RUN so the pins stay blank and inactive while idle.
    assign hs0 = run && (h_cnt < H_S);
    assign vs0 = run && (v_cnt < V_S);
    assign act0 = run && (h_cnt >= H_A0) && (h_cnt < H_A1) && (v_cnt >= V_A0) && (v_cnt < V_A1);
    assign fifo_rd_en = act0 && !fifo_empty;
    assign lcd_framesync = (run && h_cnt == '0 && v_cnt == '0) || idle_pulse;

    always_comb begin
        state_nx = state;
        if (run)
            state_nx = (last && frame_bad) ? IDLE : RUN;
        else
            state_nx = (fifo_rd_cnt >= START) ? RUN : IDLE;
    end

    always_ff @(posedge fifo_rd_clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge fifo_rd_clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
            frame_bad <= 1'b0;
            underflow <= 1'b0;
            armed <= 1'b1;
            idle_pulse <= 1'b0;
            {hs1, vs1, act1, pop1} <= '0;
            lcd_hs <= ~SYNC_POL;
            lcd_vs <= ~SYNC_POL;
            lcd_de <= 1'b0;
            lcd_data <= '0;
        end else begin
            armed <= 1'b0;
            // Write side realigns on the first idle cycle after reset and after every abort.
            idle_pulse <= armed || (run && state_nx == IDLE);
            if (run) begin
                h_cnt <= (h_cnt == H_L) ? '0 : h_cnt + 1'b1;
                if (h_cnt == H_L)
                    v_cnt <= (v_cnt == V_L) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= '0;
                v_cnt <= '0;
            end
            if (act0 && fifo_empty) begin
                frame_bad <= 1'b1;
                underflow <= 1'b1;
            end else if (run && last) begin
                frame_bad <= 1'b0;
            end
            {hs1, vs1, act1, pop1} <= {hs0, vs0, act0, fifo_rd_en};
            lcd_hs <= hs1 ? SYNC_POL : ~SYNC_POL;
            lcd_vs <= vs1 ? SYNC_POL : ~SYNC_POL;
            lcd_de <= act1;
            lcd_data <= act1 ? (pop1 ? fifo_dout : UNDERFLOW_COLOR) : '0;
        end
    end
endmodule

// File: tb/tb_lcd_fifo_rd_ctl.sv
// tb_lcd_fifo_rd_ctl: scoreboard bench on a 10x5 timing, active-low and active-high sync instances.
module tb_lcd_fifo_rd_ctl;
    localparam logic [15:0] UF = 16'hF800;
    localparam logic [7:0] IDLE_CTL = 8'b0001_1000;

    logic clk = 1'b0, rst = 1'b1, fifo_empty = 1'b1;
    logic [10:0] fifo_rd_cnt = '0;
    logic [15:0] fifo_dout = '0;
    logic fifo_rd_en, lcd_framesync, lcd_hs, lcd_vs, lcd_de, underflow;
    logic [15:0] lcd_data;
    logic p_rd_en, p_fs, p_hs, p_vs, p_de, p_uf;
    logic [15:0] p_data;
    logic [15:0] fq[$], exp_q[$];
    logic pop_now = 1'b0;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    lcd_fifo_rd_ctl #(.DATA_W(16), .CNT_W(11), .START_LEVEL(4), .H_SYNC(2), .H_BP(2), .H_ACTIVE(4),
        .H_FP(2), .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_FP(1), .SYNC_POL(1'b0)) dut (
        .fifo_rd_clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .fifo_rd_cnt(fifo_rd_cnt), .lcd_framesync(lcd_framesync),
        .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_data(lcd_data), .underflow(underflow));

    lcd_fifo_rd_ctl #(.DATA_W(16), .CNT_W(11), .START_LEVEL(4), .H_SYNC(2), .H_BP(2), .H_ACTIVE(4),
        .H_FP(2), .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_FP(1), .SYNC_POL(1'b1)) dut_p (
        .fifo_rd_clk(clk), .rst(rst), .fifo_rd_en(p_rd_en), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .fifo_rd_cnt(fifo_rd_cnt), .lcd_framesync(p_fs),
        .lcd_hs(p_hs), .lcd_vs(p_vs), .lcd_de(p_de), .lcd_data(p_data), .underflow(p_uf));

    // Standard-mode FIFO model: data appears the cycle after the pop strobe.
    always @(negedge clk) begin
        #2;
        pop_now = fifo_rd_en;
    end
    always @(posedge clk) begin
        if (pop_now) begin
            if (fq.size() > 0) fifo_dout <= fq.pop_front();
            else fifo_dout <= 16'hDEAD;
        end
    end

    function automatic bit act_at(int p);
        return (p % 10) >= 4 && (p % 10) < 8 && ((p / 10) % 5) >= 2 && ((p / 10) % 5) < 4;
    endfunction
    function automatic bit hs_at(int p);
        return (p % 10) < 2;
    endfunction
    function automatic bit vs_at(int p);
        return ((p / 10) % 5) == 0;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        fifo_rd_cnt = '0;
        fifo_empty = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if ({lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow} !== IDLE_CTL || lcd_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_values ctl=%b data=%h exp ctl=%b data=0000",
                {lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow}, lcd_data, IDLE_CTL);
        end
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            logic [7:0] e;
            @(negedge clk);
            #1;
            e = IDLE_CTL | {(c == 1), 7'b0};
            n_chk++;
            if ({lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow} !== e || lcd_data !== 16'h0) begin
                n_fail++;
                $display("FAIL idle_after_reset c=%0d ctl=%b data=%h exp ctl=%b data=0000", c,
                    {lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow}, lcd_data, e);
            end
        end
    endtask

    task automatic test_frame();
        fifo_rd_cnt = 11'd3;
        repeat (5) begin
            @(negedge clk);
            #1;
            n_chk++;
            if ({lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow} !== IDLE_CTL) begin
                n_fail++;
                $display("FAIL below_start_level ctl=%b exp %b",
                    {lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow}, IDLE_CTL);
            end
        end
        fq.delete();
        exp_q.delete();
        for (int i = 1; i <= 8; i++) begin
            fq.push_back(16'(i));
            exp_q.push_back(16'(i));
        end
        fifo_empty = 1'b0;
        fifo_rd_cnt = 11'd4;
        for (int t = 0; t < 50; t++) begin
            int p;
            bit v, e_de, e_hs, e_vs;
            logic [7:0] e;
            logic [15:0] e_data;
            @(negedge clk);
            #1;
            p = t - 2;
            v = p >= 0;
            e_de = v && act_at(p);
            e_hs = v && hs_at(p);
            e_vs = v && vs_at(p);
            e = {(t == 0), act_at(t), e_de, !e_hs, !e_vs, e_hs, e_vs, 1'b0};
            n_chk++;
            if ({lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow} !== e) begin
                n_fail++;
                $display("FAIL frame_ctl t=%0d ctl=%b exp %b", t,
                    {lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow}, e);
            end
            e_data = 16'h0;
            if (e_de) begin
                if (exp_q.size() > 0) e_data = exp_q.pop_front();
                else e_data = 16'hBAD0;
            end
            n_chk++;
            if (lcd_data !== e_data) begin
                n_fail++;
                $display("FAIL frame_data t=%0d got %h exp %h", t, lcd_data, e_data);
            end
        end
    endtask

    task automatic test_underflow();
        fq.delete();
        exp_q.delete();
        for (int i = 1; i <= 8; i++) fq.push_back(16'h0100 + 16'(i));
        exp_q = '{16'h0101, 16'h0102, UF, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107};
        fifo_rd_cnt = '0;
        for (int t = 0; t < 50; t++) begin
            int p;
            bit e_de, e_hs, e_vs;
            logic [7:0] e;
            logic [15:0] e_data;
            @(negedge clk);
            fifo_empty = (t == 26);
            #1;
            p = (t < 2) ? t + 48 : t - 2;
            e_de = act_at(p);
            e_hs = hs_at(p);
            e_vs = vs_at(p);
            e = {(t == 0), act_at(t) && t != 26, e_de, !e_hs, !e_vs, e_hs, e_vs, (t >= 27)};
            n_chk++;
            if ({lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow} !== e) begin
                n_fail++;
                $display("FAIL underflow_ctl t=%0d ctl=%b exp %b", t,
                    {lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow}, e);
            end
            e_data = 16'h0;
            if (e_de) begin
                if (exp_q.size() > 0) e_data = exp_q.pop_front();
                else e_data = 16'hBAD0;
            end
            n_chk++;
            if (lcd_data !== e_data) begin
                n_fail++;
                $display("FAIL underflow_data t=%0d got %h exp %h", t, lcd_data, e_data);
            end
        end
        for (int c = 0; c < 6; c++) begin
            logic [7:0] e;
            @(negedge clk);
            #1;
            e = IDLE_CTL | {(c == 0), 6'b0, 1'b1};
            n_chk++;
            if ({lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow} !== e || lcd_data !== 16'h0 || p_uf !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_idle c=%0d ctl=%b data=%h p_uf=%b exp ctl=%b data=0000 p_uf=1", c,
                    {lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow}, lcd_data, p_uf, e);
            end
        end
        fifo_rd_cnt = 11'd4;
        @(negedge clk);
        #1;
        n_chk++;
        if ({lcd_framesync, fifo_rd_en, underflow} !== 3'b101) begin
            n_fail++;
            $display("FAIL rerun_framesync fs/rd/uf=%b exp 101", {lcd_framesync, fifo_rd_en, underflow});
        end
    endtask

    task automatic test_reset_mid();
        fq.delete();
        exp_q.delete();
        for (int i = 1; i <= 4; i++) begin
            fq.push_back(16'hA000 + 16'(i));
            exp_q.push_back(16'hA000 + 16'(i));
        end
        fifo_empty = 1'b0;
        for (int t = 1; t <= 28; t++) begin
            bit e_de;
            logic [15:0] e_data;
            @(negedge clk);
            #1;
            e_de = (t >= 2) && act_at(t - 2);
            n_chk++;
            if ({fifo_rd_en, lcd_de, underflow} !== {act_at(t), e_de, 1'b1}) begin
                n_fail++;
                $display("FAIL rerun_ctl t=%0d rd/de/uf=%b exp %b", t, {fifo_rd_en, lcd_de, underflow}, {act_at(t), e_de, 1'b1});
            end
            if (e_de) begin
                if (exp_q.size() > 0) e_data = exp_q.pop_front();
                else e_data = 16'hBAD0;
                n_chk++;
                if (lcd_data !== e_data) begin
                    n_fail++;
                    $display("FAIL rerun_data t=%0d got %h exp %h", t, lcd_data, e_data);
                end
            end
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow} !== IDLE_CTL || lcd_data !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset ctl=%b data=%h exp ctl=%b data=0000",
                {lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow}, lcd_data, IDLE_CTL);
        end
        repeat (2) @(negedge clk);
        fifo_rd_cnt = '0;
        fq.delete();
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            logic [7:0] e;
            @(negedge clk);
            #1;
            e = IDLE_CTL | {(c == 1), 7'b0};
            n_chk++;
            if ({lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow} !== e) begin
                n_fail++;
                $display("FAIL post_reset c=%0d ctl=%b exp %b", c,
                    {lcd_framesync, fifo_rd_en, lcd_de, lcd_hs, lcd_vs, p_hs, p_vs, underflow}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_underflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
